sc_chain_ctrl: RTL
==================

// Module: sc_chain_ctrl
// PURPOSE
//  Single-clock sequencer upstream of an N-cell two-phase scan chain. From one START
//  request it generates SEL/SCK1/SCK2/LAT, serially loads a CHAIN_LEN-bit word into
//  the chain, and optionally captures chain PIN data first and latches PO last.
//  It returns the captured word to the host and sits between the host/CPU and the chain.
// PARAMETERS
//  CHAIN_LEN  32  number of cells in the chain; legal values are >= 2
//  PHASE_CYC  1   CLK cycles each of SCK1, SCK2 and LAT stays high; legal values are >= 1
// PORTS
//  CLK     in   1          system clock; all logic runs on its rising edge
//  RST_N   in   1          reset; synchronous and active-low
//  START   in   1          request pulse; sampled only in IDLE
//  CAP_EN  in   1          run the capture phase before shifting; sampled with START
//  LAT_EN  in   1          run the latch phase after shifting; sampled with START
//  DIN     in   CHAIN_LEN  word to shift in; sampled with START
//  DOUT    out  CHAIN_LEN  captured/shifted-out word; valid from DONE until the next START
//  BUSY    out  1          high in every state except IDLE
//  DONE    out  1          1-cycle pulse when the sequence completes
//  SEL     out  1          chain SEL; high only during the capture phase
//  SCK1    out  1          chain shift clock, phase 1
//  SCK2    out  1          chain shift clock, phase 2
//  LAT     out  1          chain PO latch strobe
//  SIN     out  1          serial data into the first chain cell
//  SO      in   1          serial data from the last chain cell
// BEHAVIOUR
//  - Reset: with RST_N=0 at a CLK edge, the block goes to IDLE. All outputs go to 0,
//    including DOUT, and the shift register and counters clear. This also applies
//    mid-sequence; the partial operation is abandoned without a DONE pulse.
//  - All chain-facing outputs (SEL, SCK1, SCK2, LAT, SIN) come straight from flops.
//    They use a registered next-state decode and have no combinational path.
//  - Invariants: SCK1 and SCK2 are never high together. At least one cycle with both
//    low separates every SCK1 pulse from the next SCK2 pulse, and vice versa.
//    SEL and SIN are stable whenever SCK1 is high. LAT is never high together with
//    SCK1 or SCK2.
//  - FSM (P=PHASE_CYC, each state lasts 1 cycle unless noted):
//    IDLE: on START, load shreg<=DIN, store CAP_EN/LAT_EN, clear the bit counter.
//      Go to CAP_SU if CAP_EN, otherwise SH_SU.
//    CAP_SU (SEL=1) -> CAP_P1 (SEL=1,SCK1=1; P cycles) -> CAP_G (SEL=1)
//      -> CAP_P2 (SEL=1,SCK2=1; P cycles) -> SH_SU.
//    SH_SU: SEL=0; SIN=shreg[0]; register SO into so_q.
//    SH_P1 (SCK1=1; P cycles) -> SH_G -> SH_P2 (SCK2=1; P cycles).
//      On the last SH_P2 cycle: shreg<={so_q,shreg[N-1:1]} and the bit counter
//      increments. If the counter was N-1, go to LAT_SU when LAT_EN, else FIN.
//      Otherwise return to SH_SU.
//    LAT_SU (all low) -> LAT_P (LAT=1; P cycles) -> FIN.
//    FIN: DONE=1; DOUT<=shreg; go to IDLE.
//  - Bit order: DIN[0] is shifted first and ends in the last cell, next to SO.
//    DOUT[i] is the SO value sampled before shift i. With CAP_EN, that is the PIN
//    captured by the cell that is i positions from SO.
//  - Latency from the START edge to DONE high is C + N*(2P+2) + L + 1 cycles.
//    C = 2P+2 if CAP_EN, else 0. L = P+1 if LAT_EN, else 0.
//  - START while BUSY is ignored, with no queueing. START and DONE in the same
//    cycle: START is ignored.
//  - Counters: the phase counter is $clog2(P+1) bits wide and the bit counter is
//    $clog2(N) bits wide. Both reload at each state entry with no wrap. With P=1
//    the phase counter is unused.
// STRUCTURE
//  - sc_ctrl_defs.vh holds the FSM state encodings (IDLE, CAP_SU, CAP_P1, CAP_G,
//    CAP_P2, SH_SU, SH_P1, SH_G, SH_P2, LAT_SU, LAT_P, FIN), shared with the bench.
//  - A single module; no sub-module is needed. The phase counter and bit counter are
//    inline always blocks.
//  - The bench chain is built from CHAIN_LEN SC_CELL_V3 instances with BYP_N=1.
// TESTING
//  1. Reset: N=8, P=1, hold RST_N=0 for 3 cycles -> all outputs 0, BUSY=0.
//  2. Shift only: N=8, P=1, DIN=8'hA5, CAP_EN=0, LAT_EN=0.
//     -> DONE in cycle 33 after the START edge, DOUT = previous chain contents.
//     A second run with DIN=0 returns DOUT=8'hA5.
//  3. Full run: N=8, P=2, PIN=8'h3C, DIN=8'hC3, CAP_EN=1, LAT_EN=1.
//     -> DONE in cycle 6+48+3+1=58, DOUT=8'h3C, chain PO=8'hC3 after LAT.
//  4. Protocol checker runs on every test: never SCK1&SCK2, never LAT with either
//     clock, SEL and SIN stable while SCK1=1, exactly N SCK2 pulses per shift phase.
//  5. START pulsed every cycle while BUSY -> exactly one DONE per sequence, DOUT
//     unchanged by the ignored requests.
//  6. RST_N=0 in the middle of shift bit 4 -> the next cycle is IDLE with all
//     outputs 0, no DONE. A new START then completes normally.

Source files
------------

// File: rtl/sc_chain_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sc_chain_ctrl_pkg
// Shared definitions for the two-phase scan chain sequencer: the FSM state
// encoding and small helpers that classify states into the phase groups that
// drive the chain-facing strobes.
// -----------------------------------------------------------------------------
package sc_chain_ctrl_pkg;

    // One state per step of the capture / shift / latch sequence.
    typedef enum logic [3:0] {
        S_IDLE,
        S_CAP_SU,
        S_CAP_P1,
        S_CAP_G,
        S_CAP_P2,
        S_SH_SU,
        S_SH_P1,
        S_SH_G,
        S_SH_P2,
        S_LAT_SU,
        S_LAT_P,
        S_FIN
    } state_t;

    // Capture states are the only ones in which SEL is high.
    function automatic logic is_cap_state(input state_t s);
        return (s == S_CAP_SU) || (s == S_CAP_P1) ||
               (s == S_CAP_G)  || (s == S_CAP_P2);
    endfunction

    // Shift states are the only ones in which SIN carries data.
    function automatic logic is_shift_state(input state_t s);
        return (s == S_SH_SU) || (s == S_SH_P1) ||
               (s == S_SH_G)  || (s == S_SH_P2);
    endfunction

    // States that last PHASE_CYC cycles and therefore use the phase counter.
    function automatic logic is_timed_state(input state_t s);
        return (s == S_CAP_P1) || (s == S_CAP_P2) || (s == S_SH_P1) ||
               (s == S_SH_P2)  || (s == S_LAT_P);
    endfunction

endpackage

// File: rtl/sc_chain_ctrl.sv
// -----------------------------------------------------------------------------
// sc_chain_ctrl
// Sequencer between a host and an N-cell two-phase scan chain. One START
// request optionally captures the chain's parallel inputs, serially shifts a
// CHAIN_LEN-bit word in (LSB first) while collecting the word shifted out,
// optionally strobes the chain's PO latch, then pulses DONE with the collected
// word on DOUT.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    synchronous active-low reset
//   i_start    request pulse, honoured only in IDLE
//   i_cap_en   run the capture phase first (sampled with START)
//   i_lat_en   run the latch phase last (sampled with START)
//   i_din      word to shift into the chain (sampled with START)
//   o_dout     word shifted out of the chain, valid from DONE to next START
//   o_busy     high in every state except IDLE
//   o_done     one-cycle completion pulse
//   o_sel      chain SEL, high only during capture
//   o_sck1     chain shift clock, phase 1
//   o_sck2     chain shift clock, phase 2
//   o_lat      chain PO latch strobe
//   o_sin      serial data into the first chain cell
//   i_so       serial data from the last chain cell
// -----------------------------------------------------------------------------
module sc_chain_ctrl
    import sc_chain_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int PHASE_CYC = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_cap_en,
    input  logic                 i_lat_en,
    input  logic [CHAIN_LEN-1:0] i_din,
    output logic [CHAIN_LEN-1:0] o_dout,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_sel,
    output logic                 o_sck1,
    output logic                 o_sck2,
    output logic                 o_lat,
    output logic                 o_sin,
    input  logic                 i_so
);

    localparam int PH_W  = $clog2(PHASE_CYC + 1);
    localparam int BIT_W = $clog2(CHAIN_LEN);

    state_t               r_state;
    logic [CHAIN_LEN-1:0] r_shreg;
    logic                 r_lat_en;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [PH_W-1:0]      r_phase;
    logic                 r_so_q;
    logic [CHAIN_LEN-1:0] r_dout;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_sel;
    logic                 r_sck1;
    logic                 r_sck2;
    logic                 r_lat;
    logic                 r_sin;

    state_t               w_next;
    logic [CHAIN_LEN-1:0] w_shreg_next;
    logic                 w_phase_done;
    logic                 w_bit_last;
    logic                 w_bit_inc;

    assign w_phase_done = (r_phase == '0);
    assign w_bit_last   = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));

    // Next-state and next shift-register value. The shift register's next value
    // is computed here so the registered SIN decode sees the bit that will be
    // at shreg[0] once the transition has happened.
    always_comb begin
        w_next       = r_state;
        w_shreg_next = r_shreg;
        w_bit_inc    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_shreg_next = i_din;
                    w_next       = i_cap_en ? S_CAP_SU : S_SH_SU;
                end
            end
            S_CAP_SU: w_next = S_CAP_P1;
            S_CAP_P1: if (w_phase_done) w_next = S_CAP_G;
            S_CAP_G:  w_next = S_CAP_P2;
            S_CAP_P2: if (w_phase_done) w_next = S_SH_SU;
            S_SH_SU:  w_next = S_SH_P1;
            S_SH_P1:  if (w_phase_done) w_next = S_SH_G;
            S_SH_G:   w_next = S_SH_P2;
            S_SH_P2: begin
                if (w_phase_done) begin
                    // so_q holds the bit that left the chain before this shift
                    w_shreg_next = {r_so_q, r_shreg[CHAIN_LEN-1:1]};
                    if (w_bit_last) begin
                        w_next = r_lat_en ? S_LAT_SU : S_FIN;
                    end else begin
                        w_bit_inc = 1'b1;
                        w_next    = S_SH_SU;
                    end
                end
            end
            S_LAT_SU: w_next = S_LAT_P;
            S_LAT_P:  if (w_phase_done) w_next = S_FIN;
            S_FIN:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register, shift register and latched request options.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_shreg  <= '0;
            r_lat_en <= 1'b0;
            r_so_q   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_shreg <= w_shreg_next;
            if ((r_state == S_IDLE) && i_start) begin
                r_lat_en <= i_lat_en;
            end
            if (r_state == S_SH_SU) begin
                r_so_q <= i_so;
            end
        end
    end

    // Phase counter: reloaded with P-1 on every state change and counted down
    // to zero, so a timed state lasts exactly PHASE_CYC cycles. It stops at
    // zero rather than wrapping.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (w_next != r_state) begin
            r_phase <= is_timed_state(w_next) ? PH_W'(PHASE_CYC - 1) : '0;
        end else if (!w_phase_done) begin
            r_phase <= r_phase - 1'b1;
        end
    end

    // Bit counter: cleared when a request is accepted, advanced after each
    // completed shift except the last, so it never wraps.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bit_cnt <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_bit_cnt <= '0;
        end else if (w_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Output flops decoded from the next state, so every strobe changes on
    // the same edge as the state and no output has a combinational path.
    // DOUT is loaded on entry to FIN so it is valid in the DONE cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dout <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sel  <= 1'b0;
            r_sck1 <= 1'b0;
            r_sck2 <= 1'b0;
            r_lat  <= 1'b0;
            r_sin  <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_FIN);
            r_sel  <= is_cap_state(w_next);
            r_sck1 <= (w_next == S_CAP_P1) || (w_next == S_SH_P1);
            r_sck2 <= (w_next == S_CAP_P2) || (w_next == S_SH_P2);
            r_lat  <= (w_next == S_LAT_P);
            r_sin  <= is_shift_state(w_next) ? w_shreg_next[0] : 1'b0;
            if (w_next == S_FIN) begin
                r_dout <= w_shreg_next;
            end
        end
    end

    assign o_dout = r_dout;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_sel  = r_sel;
    assign o_sck1 = r_sck1;
    assign o_sck2 = r_sck2;
    assign o_lat  = r_lat;
    assign o_sin  = r_sin;

endmodule
